// File: rtl/fp_dot_seq_if.sv
// Bundles the upstream operand/result handshake and the FP core
// request/response signals used by fp_dot_seq.
//   slave  : view taken by fp_dot_seq
//   master : view taken by the upstream producer and the FP core
// Signals:
//   in_valid/in_a/in_b/in_ready : upstream operand pair handshake
//   out_valid/out               : dot product result pulse
//   core_in_valid/core_in_a/core_in_b/core_mode : core request
//   core_out_valid/core_out     : core response
interface fp_dot_seq_if;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out;
  logic        core_in_valid;
  logic [15:0] core_in_a;
  logic [15:0] core_in_b;
  logic        core_mode;
  logic        core_out_valid;
  logic [15:0] core_out;

  modport slave (
    input  in_valid, in_a, in_b, core_out_valid, core_out,
    output in_ready, out_valid, out, core_in_valid, core_in_a, core_in_b, core_mode
  );

  modport master (
    output in_valid, in_a, in_b, core_out_valid, core_out,
    input  in_ready, out_valid, out, core_in_valid, core_in_a, core_in_b, core_mode
  );
endinterface

// File: rtl/fp_dot_seq.sv
// Sequential dot-product initiator for the 16-bit FP compute core
// (sign[15], exp[14:7] bias 127, frac[6:0]).
// Collects NUM_PAIRS operand pairs, then drives 2*NUM_PAIRS-1 core
// transactions: MUL(a0,b0)->acc, then per further pair MUL(ai,bi)->tmp
// followed by ADD(acc,tmp)->acc. The final acc is returned as a
// single-cycle out_valid pulse. No arithmetic is done here.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fp_dot_seq_if.slave (upstream handshake + core request/response)
module fp_dot_seq #(
  parameter int NUM_PAIRS = 4,
  parameter int CNT_W     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_dot_seq_if.slave   bus
);

  localparam int TW = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(NUM_PAIRS - 1);
  localparam logic [TW-1:0]    LAST_TXN  = TW'(2 * NUM_PAIRS - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [15:0]      a_buf [NUM_PAIRS];
  logic [15:0]      b_buf [NUM_PAIRS];
  logic [CNT_W-1:0] load_cnt;
  logic [TW-1:0]    txn;
  logic [15:0]      acc;
  logic [15:0]      tmp;

  logic             accept;
  logic             last_beat;
  logic             resp;
  logic             txn_mul;
  logic [TW-1:0]    txn_p1;
  logic [CNT_W-1:0] pair_sel;

  // Transaction t uses pair (t+1)/2: t=0 -> 0, t=1,2 -> 1, t=3,4 -> 2, ...
  // t=0 and odd t are multiplies; even t>0 are ADD(acc,tmp).
  assign txn_p1    = txn + 1'b1;
  assign pair_sel  = txn_p1[TW-1:1];
  assign txn_mul   = (txn == '0) || txn[0];
  assign accept    = bus.in_valid && bus.in_ready;
  assign last_beat = accept && (load_cnt == LAST_PAIR);
  assign resp      = (state == S_WAIT) && bus.core_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx          = state;
    bus.in_ready      = 1'b0;
    bus.out_valid     = 1'b0;
    bus.out           = '0;
    bus.core_in_valid = 1'b0;
    bus.core_in_a     = '0;
    bus.core_in_b     = '0;
    bus.core_mode     = 1'b0;
    unique case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (last_beat) begin
          state_nx = S_ISSUE;
        end else if (accept) begin
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (last_beat) begin
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.core_in_valid = 1'b1;
        bus.core_mode     = txn_mul;
        bus.core_in_a     = txn_mul ? a_buf[pair_sel] : acc;
        bus.core_in_b     = txn_mul ? b_buf[pair_sel] : tmp;
        state_nx          = S_WAIT;
      end
      S_WAIT: begin
        if (bus.core_out_valid) begin
          state_nx = (txn == LAST_TXN) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        bus.out       = acc;
        state_nx      = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PAIRS; i++) begin
        a_buf[i] <= '0;
        b_buf[i] <= '0;
      end
      load_cnt <= '0;
      txn      <= '0;
      acc      <= '0;
      tmp      <= '0;
    end else begin
      if (accept) begin
        a_buf[load_cnt] <= bus.in_a;
        b_buf[load_cnt] <= bus.in_b;
        load_cnt        <= last_beat ? '0 : load_cnt + 1'b1;
      end
      if (resp) begin
        // Odd transactions are the MUL(ai,bi) partial products.
        if (txn[0]) begin
          tmp <= bus.core_out;
        end else begin
          acc <= bus.core_out;
        end
        txn <= (txn == LAST_TXN) ? '0 : txn + 1'b1;
      end
    end
  end

endmodule
